// File: rtl/counter_timer_arbiter.sv
// Round-robin owner of a shared 4-bit counter used as an interval timer.
// Ports: clk, rst (sync, active-high); req/req_periods in; grant/busy/done/
//   done_id/aborted out; cnt_rst_n/cnt_enable drive the counter;
//   cnt_count/cnt_overflow come back from it.
module counter_timer_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 8,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*PW-1:0] req_periods,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              done,
   output logic [IW-1:0]     done_id,
   output logic              aborted,
   output logic              cnt_rst_n,
   output logic              cnt_enable,
   input  logic [3:0]        cnt_count,
   input  logic              cnt_overflow
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t        state;
   logic [IW-1:0] winner;
   logic [IW-1:0] rr_ptr;
   logic [PW-1:0] remaining;

   logic [IW-1:0] pick;
   logic          found;
   logic [PW-1:0] pick_per;
   logic [IW-1:0] next_ptr;
   logic          unused_cnt;

   // Counter value is observed by the bench only.
   assign unused_cnt = ^cnt_count;

   // First set request at or after rr_ptr, wrapping upward.
   always_comb begin : rr_pick
      int j;
      j     = 0;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(rr_ptr) + k) % NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = IW'(j);
         end
      end
   end

   assign pick_per = req_periods[int'(pick)*PW +: PW];
   assign next_ptr = (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;

   always_comb begin
      grant = '0;
      if (state == CLEAR || state == RUN)
         grant[winner] = 1'b1;
   end

   assign busy       = (state != IDLE);
   assign cnt_enable = (state == RUN);
   // Held low through reset so the counter starts clear.
   assign cnt_rst_n  = ~(rst | (state == CLEAR));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         winner    <= '0;
         rr_ptr    <= '0;
         remaining <= '0;
         done      <= 1'b0;
         done_id   <= '0;
         aborted   <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  winner    <= pick;
                  remaining <= pick_per;
                  if (pick_per == '0) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     done_id <= pick;
                  end else begin
                     state <= CLEAR;
                  end
               end
            end
            CLEAR: state <= RUN;
            RUN: begin
               // Owner drop wins over a same-cycle overflow.
               if (!req[winner]) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  done_id <= winner;
                  aborted <= 1'b1;
               end else if (cnt_overflow) begin
                  if (remaining == PW'(1)) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     done_id <= winner;
                  end else begin
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            DONE: begin
               rr_ptr <= next_ptr;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Self-checking bench for counter_timer_arbiter with a behavioural
// 4-bit counter attached to the cnt_* ports.
module tb_counter_timer_arbiter;

   localparam int NREQ = 4;
   localparam int PW   = 8;
   localparam int IW   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*PW-1:0] req_periods;
   logic [NREQ-1:0]   grant;
   logic              busy, done, aborted;
   logic [IW-1:0]     done_id;
   logic              cnt_rst_n, cnt_enable;
   logic [3:0]        cnt_count;
   logic              cnt_overflow;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   counter_timer_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_periods(req_periods),
      .grant(grant), .busy(busy), .done(done), .done_id(done_id),
      .aborted(aborted), .cnt_rst_n(cnt_rst_n), .cnt_enable(cnt_enable),
      .cnt_count(cnt_count), .cnt_overflow(cnt_overflow)
   );

   always_ff @(posedge clk) begin
      if (!cnt_rst_n)
         cnt_count <= 4'd0;
      else if (cnt_enable)
         cnt_count <= cnt_count + 4'd1;
   end
   assign cnt_overflow = cnt_enable && (cnt_count == 4'd15);

   typedef struct {
      logic [3:0]  req;
      logic [31:0] per;
      logic [3:0]  g;
      logic        busy;
      logic        done;
      logic [1:0]  id;
      logic        ab;
      logic        rn;
      logic        en;
   } vec_t;

   vec_t tv[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Steps until done is seen or the cycle budget runs out.
   task automatic watch(input int limit, input int drop_at,
                        output int dstep, output int en_n,
                        output int ov_n, output int rl_n,
                        output logic [3:0] g1, output logic [1:0] id,
                        output logic ab, output logic ov_drop);
      dstep = -1; en_n = 0; ov_n = 0; rl_n = 0;
      g1 = '0; id = '0; ab = 1'b0; ov_drop = 1'b0;
      for (int s = 1; s <= limit; s++) begin
         step();
         if (s == 1) g1 = grant;
         if (cnt_enable) en_n++;
         if (cnt_overflow) ov_n++;
         if (!cnt_rst_n) rl_n++;
         if (done) begin
            dstep = s; id = done_id; ab = aborted;
            break;
         end
         if (s == drop_at) begin
            ov_drop = cnt_overflow;
            req = '0;
         end
      end
   endtask

   int          ds, en_n, ov_n, rl_n;
   logic [3:0]  g1;
   logic [1:0]  id;
   logic        ab, ovd;
   logic [1:0]  exp_ids [4];

   initial begin
      tv[0] = '{4'b0100, 32'h0, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
      tv[1] = '{4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
      tv[2] = '{4'b0101, 32'h00010001, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      tv[3] = '{4'b0101, 32'h00010001, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
      tv[4] = '{4'b0100, 32'h00010001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
      tv[5] = '{4'b0100, 32'h00010001, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
      tv[6] = '{4'b0100, 32'h00010001, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      tv[7] = '{4'b0000, 32'h00010001, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
      tv[8] = '{4'b0000, 32'h00010001, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
      tv[9] = '{4'b0000, 32'h00010001, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
      exp_ids[0] = 2'd0; exp_ids[1] = 2'd1;
      exp_ids[2] = 2'd3; exp_ids[3] = 2'd0;

      rst = 1'b1; req = '0; req_periods = '0;
      step(); step();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_done_id", 32'(done_id), 0);
      chk("rst_aborted", 32'(aborted), 0);
      chk("rst_en", 32'(cnt_enable), 0);
      chk("rst_cnt_rst_n", 32'(cnt_rst_n), 0);
      rst = 1'b0;
      step();
      chk("post_rst_cnt_rst_n", 32'(cnt_rst_n), 1);
      chk("post_rst_busy", 32'(busy), 0);

      // Zero-length job, round-robin pick from rr_ptr=3, abort paths.
      for (int i = 0; i < 10; i++) begin
         req = tv[i].req;
         req_periods = tv[i].per;
         step();
         chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tv[i].g));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
         chk($sformatf("v%0d_done", i), 32'(done), 32'(tv[i].done));
         chk($sformatf("v%0d_rst_n", i), 32'(cnt_rst_n), 32'(tv[i].rn));
         chk($sformatf("v%0d_en", i), 32'(cnt_enable), 32'(tv[i].en));
         if (tv[i].done) begin
            chk($sformatf("v%0d_id", i), 32'(done_id), 32'(tv[i].id));
            chk($sformatf("v%0d_ab", i), 32'(aborted), 32'(tv[i].ab));
         end
      end

      // Single request, one period.
      req = 4'b0001; req_periods = 32'h00000001;
      watch(40, -1, ds, en_n, ov_n, rl_n, g1, id, ab, ovd);
      chk("single_grant_t1", 32'(g1), 32'b0001);
      chk("single_done_step", 32'(ds), 18);
      chk("single_en_cycles", 32'(en_n), 16);
      chk("single_rst_low", 32'(rl_n), 1);
      chk("single_ovf", 32'(ov_n), 1);
      chk("single_id", 32'(id), 0);
      chk("single_ab", 32'(ab), 0);
      req = '0; step();

      // Three periods.
      req = 4'b0010; req_periods = 32'h00000300;
      watch(80, -1, ds, en_n, ov_n, rl_n, g1, id, ab, ovd);
      chk("multi_done_step", 32'(ds), 50);
      chk("multi_en_cycles", 32'(en_n), 48);
      chk("multi_ovf", 32'(ov_n), 3);
      chk("multi_id", 32'(id), 1);
      req = '0; step();

      // Contention from rr_ptr=0.
      rst = 1'b1; step(); rst = 1'b0;
      req = 4'b1011; req_periods = 32'h01010101;
      for (int j = 0; j < 4; j++) begin
         watch(40, -1, ds, en_n, ov_n, rl_n, g1, id, ab, ovd);
         chk($sformatf("cont%0d_id", j), 32'(id), 32'(exp_ids[j]));
         chk($sformatf("cont%0d_step", j), 32'(ds), (j == 0) ? 18 : 19);
         if (j == 0) chk("cont_grant", 32'(g1), 32'b0001);
      end
      req = '0; step(); step();

      // Abort in RUN cycle 20 of a five-period job.
      req = 4'b0100; req_periods = 32'h00050000;
      watch(120, 21, ds, en_n, ov_n, rl_n, g1, id, ab, ovd);
      chk("abort_done_step", 32'(ds), 22);
      chk("abort_ab", 32'(ab), 1);
      chk("abort_id", 32'(id), 2);
      chk("abort_en_cycles", 32'(en_n), 20);
      chk("abort_ovf", 32'(ov_n), 1);
      en_n = 0;
      for (int j = 0; j < 4; j++) begin
         step();
         if (cnt_enable) en_n++;
      end
      chk("abort_en_after", 32'(en_n), 0);

      // Owner drop on the overflow cycle.
      req = 4'b1000; req_periods = 32'h01000000;
      watch(40, 17, ds, en_n, ov_n, rl_n, g1, id, ab, ovd);
      chk("coll_ovf_at_drop", 32'(ovd), 1);
      chk("coll_done_step", 32'(ds), 18);
      chk("coll_ab", 32'(ab), 1);
      chk("coll_id", 32'(id), 3);
      step();

      // Move rr_ptr to 2, then reset in RUN.
      req = 4'b0010; req_periods = 32'h0;
      step();
      chk("zero1_done", 32'(done), 1);
      chk("zero1_id", 32'(done_id), 1);
      req = '0; step();
      req = 4'b0100; req_periods = 32'h00020000;
      for (int j = 0; j < 5; j++) step();
      chk("prerst_en", 32'(cnt_enable), 1);
      rst = 1'b1; req = '0;
      step();
      chk("midrst_grant", 32'(grant), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_en", 32'(cnt_enable), 0);
      chk("midrst_cnt_rst_n", 32'(cnt_rst_n), 0);
      chk("midrst_done_id", 32'(done_id), 0);
      step();
      chk("midrst_done2", 32'(done), 0);
      rst = 1'b0;
      step();
      chk("afterrst_done", 32'(done), 0);
      chk("afterrst_cnt_rst_n", 32'(cnt_rst_n), 1);
      req = 4'b0101; req_periods = 32'h00010001;
      step();
      chk("afterrst_rr_grant", 32'(grant), 32'b0001);
      req = '0;
      step(); step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
